// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared types and defaults for the register-file write arbiter
package regfile_write_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADD_WIDTH  = 5;
    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic [DEF_ADD_WIDTH-1:0]  address;
        logic [DEF_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback request ports and register-file write port bundle
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADD_WIDTH  = DEF_ADD_WIDTH
);
    logic                    a_valid;
    logic [ADD_WIDTH-1:0]    a_address;
    logic [DATA_WIDTH-1:0]   a_data;
    logic                    a_ready;
    logic                    b_valid;
    logic [ADD_WIDTH-1:0]    b_address;
    logic [DATA_WIDTH-1:0]   b_data;
    logic                    b_ready;
    logic                    write_enable;
    logic [ADD_WIDTH-1:0]    write_address;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [2**ADD_WIDTH-1:0] busy_regs;

    modport master (
        output a_valid, a_address, a_data, b_valid, b_address, b_data,
        input  a_ready, b_ready, write_enable, write_address, write_data, busy_regs
    );

    modport slave (
        input  a_valid, a_address, a_data, b_valid, b_address, b_data,
        output a_ready, b_ready, write_enable, write_address, write_data, busy_regs
    );
endinterface

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// rtl/regfile_write_arbiter_wb_fifo.sv - synchronous FIFO buffering long-latency writeback requests
module regfile_write_arbiter_wb_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_req_t,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    output entry_t           head,
    output logic             full,
    output logic             empty,
    output entry_t           entries [DEPTH],
    output logic [DEPTH-1:0] entry_valid
);
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    entry_t           mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign entries = mem;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_push) begin
                wr_ptr              <= wr_ptr + PTR_W'(1);
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr              <= rd_ptr + PTR_W'(1);
                entry_valid[rd_ptr] <= 1'b0;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-source arbiter for the register-file write port
// Optional per-register ordering scoreboard: REGFILE_ARB_SCOREBOARD_EN
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADD_WIDTH  = DEF_ADD_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    regfile_write_arbiter_if.slave bus
);
    localparam int NUM_REGS = 2**ADD_WIDTH;
    localparam int STARVE_W = $clog2(MAX_WAIT + 2);
`ifdef REGFILE_ARB_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    typedef struct packed {
        logic [ADD_WIDTH-1:0]  address;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t                  push_entry;
    req_t                  head;
    req_t                  entries [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] entry_valid;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  b_ready_int;
    logic                  grant_a;
    logic                  grant_b;
    logic                  a_conflict;
    logic [NUM_REGS-1:0]   busy_vec;
    logic [STARVE_W-1:0]   starve;
    logic                  we_q;
    logic [ADD_WIDTH-1:0]  waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    assign push_entry  = '{address: bus.b_address, data: bus.b_data};
    assign b_ready_int = reset_n && !fifo_full;

    regfile_write_arbiter_wb_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (req_t)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (bus.b_valid && b_ready_int),
        .push_entry  (push_entry),
        .pop         (grant_b),
        .head        (head),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .entries     (entries),
        .entry_valid (entry_valid)
    );

    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i] && entries[i].address != ADD_WIDTH'(REG_ZERO)) begin
                busy_vec[entries[i].address] = 1'b1;
            end
        end
    end

    // A pending B write to the same register must drain first to keep program order.
    assign a_conflict = SB_EN && bus.a_valid && busy_vec[bus.a_address];

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (bus.a_valid && (fifo_empty || (starve < STARVE_W'(MAX_WAIT) && !a_conflict))) begin
            grant_a = 1'b1;
        end else if (!fifo_empty) begin
            grant_b = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            if (fifo_empty || grant_b) begin
                starve <= '0;
            end else if (grant_a) begin
                starve <= starve + STARVE_W'(1);
            end
            we_q <= 1'b0;
            if (grant_a) begin
                we_q    <= (bus.a_address != ADD_WIDTH'(REG_ZERO));
                waddr_q <= bus.a_address;
                wdata_q <= bus.a_data;
            end else if (grant_b) begin
                we_q    <= (head.address != ADD_WIDTH'(REG_ZERO));
                waddr_q <= head.address;
                wdata_q <= head.data;
            end
        end
    end

    assign bus.a_ready       = reset_n && grant_a;
    assign bus.b_ready       = b_ready_int;
    assign bus.write_enable  = we_q;
    assign bus.write_address = waddr_q;
    assign bus.write_data    = wdata_q;
    assign bus.busy_regs     = SB_EN ? busy_vec : '0;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
    localparam int MAX_WAIT = 3;
`ifdef REGFILE_ARB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    typedef struct {
        logic        a_valid;
        logic [4:0]  a_addr;
        logic [31:0] a_data;
        logic        exp_a_ready;
        logic        exp_b_ready;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    int          total = 0;
    int          bad = 0;
    wr_t         exp_q[$];
    logic [31:0] rf [32];
    vec_t        vecs [7];

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] addr, input logic [31:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        @(posedge clk);
        #1;
        bus.a_valid   = av;
        bus.a_address = aa;
        bus.a_data    = ad;
        bus.b_valid   = bv;
        bus.b_address = ba;
        bus.b_data    = bd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.write_enable) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                         bus.write_address, bus.write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("sb_write_address", 64'(bus.write_address), 64'(e.addr));
                chk("sb_write_data", 64'(bus.write_data), 64'(e.data));
                rf[bus.write_address] = bus.write_data;
            end
        end
    end

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 32'd0;
        bus.a_valid = 1'b0; bus.a_address = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_address = '0; bus.b_data = '0;

        for (int k = 0; k < 7; k++) begin
            vecs[k].a_valid     = (k < 5);
            vecs[k].a_addr      = 5'(k + 1);
            vecs[k].a_data      = 32'((k + 1) * 16);
            vecs[k].exp_a_ready = (k < 5);
            vecs[k].exp_b_ready = 1'b1;
            vecs[k].exp_we      = (k >= 1 && k <= 5);
            vecs[k].exp_waddr   = (k == 0) ? 5'd0 : ((k <= 5) ? 5'(k) : 5'd5);
            vecs[k].exp_wdata   = 32'(vecs[k].exp_waddr) << 4;
        end

        // reset state
        @(negedge clk);
        chk("rst_we", 64'(bus.write_enable), 64'd0);
        chk("rst_b_ready", 64'(bus.b_ready), 64'd0);
        chk("rst_waddr", 64'(bus.write_address), 64'd0);
        chk("rst_wdata", 64'(bus.write_data), 64'd0);
        @(posedge clk); #1; reset_n = 1'b1;

        // 1: A-only table
        for (int k = 0; k < 7; k++) begin
            if (vecs[k].a_valid && vecs[k].exp_a_ready) expect_wr(vecs[k].a_addr, vecs[k].a_data);
            drive(vecs[k].a_valid, vecs[k].a_addr, vecs[k].a_data, 1'b0, 5'd0, 32'd0);
            chk("t1_a_ready", 64'(bus.a_ready), 64'(vecs[k].exp_a_ready));
            chk("t1_b_ready", 64'(bus.b_ready), 64'(vecs[k].exp_b_ready));
            chk("t1_we", 64'(bus.write_enable), 64'(vecs[k].exp_we));
            chk("t1_waddr", 64'(bus.write_address), 64'(vecs[k].exp_waddr));
            chk("t1_wdata", 64'(bus.write_data), 64'(vecs[k].exp_wdata));
        end
        for (int r = 1; r <= 5; r++) chk("t1_rf", 64'(rf[r]), 64'(r * 16));

        // 2: starvation
        for (int i = 0; i < 7; i++) begin
            if (i == MAX_WAIT + 1) expect_wr(5'd7, 32'hBEEF);
            else expect_wr(5'(11 + i), 32'h100 + 32'(i));
            drive(1'b1, 5'(11 + i), 32'h100 + 32'(i), (i == 0), 5'd7, 32'hBEEF);
            chk("t2_a_ready", 64'(bus.a_ready), 64'(i != MAX_WAIT + 1));
            if (i == 0) chk("t2_b_ready", 64'(bus.b_ready), 64'd1);
            if (i == MAX_WAIT + 2) begin
                chk("t2_b_we", 64'(bus.write_enable), 64'd1);
                chk("t2_b_addr", 64'(bus.write_address), 64'd7);
            end
        end
        idle(2);
        chk("t2_drained", 64'(exp_q.size()), 64'd0);
        chk("t2_rf7", 64'(rf[7]), 64'hBEEF);

        // 3: FIFO full, A saturating
        for (int i = 0; i <= 16; i++) begin
            logic pop_cycle;
            pop_cycle = (i >= MAX_WAIT + 1) && (i % (MAX_WAIT + 1) == 0);
            if (pop_cycle) expect_wr(5'(20 + i / (MAX_WAIT + 1) - 1), 32'h200 + 32'(i / (MAX_WAIT + 1) - 1));
            else expect_wr(5'(1 + i % 15), 32'h300 + 32'(i));
            drive(1'b1, 5'(1 + i % 15), 32'h300 + 32'(i), (i <= 4), 5'(20 + i), 32'h200 + 32'(i));
            chk("t3_a_ready", 64'(bus.a_ready), 64'(!pop_cycle));
            if (i <= 4) chk("t3_b_ready", 64'(bus.b_ready), 64'(i < 4));
        end
        idle(2);
        chk("t3_drained", 64'(exp_q.size()), 64'd0);
        chk("t3_rf24_untouched", 64'(rf[24]), 64'd0);

        // 4: r0 is never written
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        chk("t4_a_ready", 64'(bus.a_ready), 64'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234);
        chk("t4_b_ready", 64'(bus.b_ready), 64'd1);
        chk("t4_we_c1", 64'(bus.write_enable), 64'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("t4_we_idle", 64'(bus.write_enable), 64'd0);
        end
        chk("t4_rf0", 64'(rf[0]), 64'd0);

        // 6: same-register ordering (scoreboard build) or plain arbitration
        expect_wr(5'd1, 32'h11);
        if (SB) begin expect_wr(5'd9, 32'hB9); expect_wr(5'd9, 32'hA9); end
        else begin expect_wr(5'd9, 32'hA9); expect_wr(5'd9, 32'hB9); end
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'hB9);
        chk("t6_a_ready_c0", 64'(bus.a_ready), 64'd1);
        drive(1'b1, 5'd9, 32'hA9, 1'b0, 5'd0, 32'd0);
        chk("t6_a_ready_c1", 64'(bus.a_ready), 64'(!SB));
        chk("t6_busy_regs", 64'(bus.busy_regs), SB ? 64'(32'h1 << 9) : 64'd0);
        drive(SB, 5'd9, 32'hA9, 1'b0, 5'd0, 32'd0);
        chk("t6_a_ready_c2", 64'(bus.a_ready), 64'(SB));
        idle(3);
        chk("t6_busy_clear", 64'(bus.busy_regs), 64'd0);
        chk("t6_drained", 64'(exp_q.size()), 64'd0);
        chk("t6_rf9", 64'(rf[9]), SB ? 64'hA9 : 64'hB9);

        // 5: reset with B entries queued
        for (int i = 0; i < 3; i++) begin
            if (i < 2) expect_wr(5'(1 + i), 32'h500 + 32'(i));
            drive(1'b1, 5'(1 + i), 32'h500 + 32'(i), 1'b1, 5'(25 + i), 32'h600 + 32'(i));
            chk("t5_a_ready", 64'(bus.a_ready), 64'd1);
            chk("t5_b_ready", 64'(bus.b_ready), 64'd1);
        end
        @(posedge clk); #1;
        reset_n = 1'b0;
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        @(negedge clk);
        chk("t5_rst_we", 64'(bus.write_enable), 64'd0);
        chk("t5_rst_waddr", 64'(bus.write_address), 64'd0);
        chk("t5_rst_b_ready", 64'(bus.b_ready), 64'd0);
        @(posedge clk); #1; reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("t5_post_we", 64'(bus.write_enable), 64'd0);
            chk("t5_post_b_ready", 64'(bus.b_ready), 64'd1);
        end
        chk("t5_drained", 64'(exp_q.size()), 64'd0);
        for (int r = 25; r <= 27; r++) chk("t5_no_stale", 64'(rf[r]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
